uart_rx_deserializer: RTL and testbench



---
 rtl/uart_rx_deserializer.sv | 143 ++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
//   UART receive front end: 2-flop input synchronizer, free-running 16x
//   oversampling tick generator and frame FSM (start, DATA_BITS data bits
//   LSB first, no parity, stop bit of SB_TICK oversample ticks).
//   rx_done/rx_data connect straight to a receive FIFO write port.
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   rx           asynchronous serial line, idle high
//   rx_data      last correctly received word
//   rx_done      one-clk strobe when rx_data is updated
//   framing_err  one-clk strobe when the stop bit is sampled low
//   busy         high whenever the FSM is not idle
module uart_rx_deserializer #(
  parameter int DATA_BITS = 8,
  parameter int SB_TICK   = 16,
  parameter int CLK_DIV   = 651,
  parameter int DIV_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 framing_err,
  output logic                 busy
);

  // s must hold 15 (data bits) as well as SB_TICK-1 (1.5/2 stop bits)
  localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  // synchronizer; flops reset to the idle (high) line level
  logic rx_m, rx_s;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // free-running oversample tick; never realigned to the start edge
  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 tick;
  assign tick = (div_cnt == DIV_WIDTH'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_WIDTH'(1);
  end

  state_t               state_q, state_d;
  logic [S_W-1:0]       s_q, s_d;
  logic [N_W-1:0]       n_q, n_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_d;
  logic                 done_d, ferr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      s_q         <= '0;
      n_q         <= '0;
      shift_q     <= '0;
      rx_data     <= '0;
      rx_done     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      shift_q     <= shift_d;
      rx_data     <= data_d;
      rx_done     <= done_d;
      framing_err <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    data_d  = rx_data;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      // start edge is looked for every clk, not only on tick
      IDLE: if (!rx_s) begin
        s_d     = '0;
        state_d = START;
      end
      START: if (tick) begin
        if (s_q == S_W'(7)) begin
          if (!rx_s) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            state_d = IDLE;  // line went back high: glitch, drop it
          end
        end else begin
          s_d = s_q + S_W'(1);
        end
      end
      DATA: if (tick) begin
        if (s_q == S_W'(15)) begin
          s_d     = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (n_q == N_W'(DATA_BITS - 1)) state_d = STOP;
          else                            n_d     = n_q + N_W'(1);
        end else begin
          s_d = s_q + S_W'(1);
        end
      end
      STOP: if (tick) begin
        if (s_q == S_W'(SB_TICK - 1)) begin
          if (rx_s) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          s_d = s_q + S_W'(1);
        end
      end
      // a held-low line (break) must go high before a new frame can start
      WAIT_IDLE: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
module tb_uart_rx_deserializer;
  localparam int DIV  = 4;
  localparam int BIT  = 16 * DIV;              // clk per serial bit
  // start edge -> pulse: 2 clk sync + (7 + 16*8 + 16) ticks, +-1 tick
  localparam int NOM  = 2 + (7 + 16 * 8 + 16) * DIV;
  localparam int WIN  = DIV + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done, framing_err, busy;

  uart_rx_deserializer #(
    .DATA_BITS(8), .SB_TICK(16), .CLK_DIV(DIV), .DIV_WIDTH(2)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_data(rx_data),
    .rx_done(rx_done), .framing_err(framing_err), .busy(busy)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // expected pulses: kind 0 = rx_done with data, 1 = framing_err
  int         q_kind[$];
  logic [7:0] q_data[$];
  longint     q_t[$];
  logic [7:0] model_data = 8'h00;

  always @(negedge clk) begin : cmp
    int         kind;
    logic [7:0] d;
    longint     t;
    if (reset) begin
      model_data = 8'h00;
    end else begin
      chk("done_ferr_exclusive", {63'd0, rx_done & framing_err}, 64'd0);
      if (rx_done || framing_err) begin
        if (q_kind.size() == 0) begin
          chk("unexpected_pulse", {62'd0, rx_done, framing_err}, 64'd0);
        end else begin
          kind = q_kind.pop_front();
          d    = q_data.pop_front();
          t    = q_t.pop_front();
          chk("pulse_kind", {62'd0, rx_done, framing_err}, (kind == 0) ? 64'd2 : 64'd1);
          n_cmp++;
          if (cyc < t - WIN || cyc > t + WIN) begin
            n_err++;
            $display("FAIL pulse_time: at cycle %0d, required %0d..%0d", cyc, t - WIN, t + WIN);
          end
          if (kind == 0) begin
            model_data = d;
            chk("busy_at_done", {63'd0, busy}, 64'd0);
          end else begin
            chk("busy_at_ferr", {63'd0, busy}, 64'd1);
          end
        end
      end else if (q_t.size() > 0 && cyc > q_t[0] + WIN) begin
        n_cmp++;
        n_err++;
        $display("FAIL missed_pulse: none by cycle %0d, required by %0d", cyc, q_t[0] + WIN);
        void'(q_kind.pop_front());
        void'(q_data.pop_front());
        void'(q_t.pop_front());
      end
      chk("rx_data", {56'd0, rx_data}, {56'd0, model_data});
    end
  end

  task automatic wait_clk(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // call aligned to posedge+1; leaves rx at the stop level
  task automatic send_frame(logic [7:0] d, bit stop_ok);
    rx = 1'b0;
    q_kind.push_back(stop_ok ? 0 : 1);
    q_data.push_back(d);
    q_t.push_back(cyc + NOM);
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clk(BIT);
    end
    rx = stop_ok;
    wait_clk(BIT);
  endtask

  initial begin
    logic [7:0] rd;
    bit         ok;
    rx    = 1'b1;
    reset = 1'b1;
    wait_clk(5);
    reset = 1'b0;

    // idle line after reset
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("idle_busy", {63'd0, busy}, 64'd0);
    end
    chk("idle_rx_data", {56'd0, rx_data}, 64'h00);
    wait_clk(1);

    // single frame
    send_frame(8'hA5, 1'b1);
    wait_clk(10);
    chk("a5_data", {56'd0, rx_data}, 64'hA5);
    chk("a5_drained", q_kind.size(), 0);

    // 12-clk low glitch is rejected at mid start bit
    rx = 1'b0;
    wait_clk(6);
    chk("glitch_busy_hi", {63'd0, busy}, 64'd1);
    wait_clk(6);
    rx = 1'b1;
    wait_clk(60);
    chk("glitch_busy_lo", {63'd0, busy}, 64'd0);
    send_frame(8'h3C, 1'b1);
    wait_clk(10);
    chk("3c_data", {56'd0, rx_data}, 64'h3C);

    // framing error, line held low (break)
    send_frame(8'h3C, 1'b0);
    wait_clk(150);
    chk("break_busy", {63'd0, busy}, 64'd1);
    chk("break_data_kept", {56'd0, rx_data}, 64'h3C);
    wait_clk(150);
    chk("break_busy2", {63'd0, busy}, 64'd1);
    rx = 1'b1;
    wait_clk(8);
    chk("break_released", {63'd0, busy}, 64'd0);
    send_frame(8'h81, 1'b1);
    wait_clk(10);
    chk("81_data", {56'd0, rx_data}, 64'h81);

    // back-to-back, zero idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_clk(10);
    chk("ff_data", {56'd0, rx_data}, 64'hFF);

    // reset during data bit 4 of 0x55
    rx = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = i[0] ? 1'b0 : 1'b1;
      wait_clk(BIT);
    end
    rx = 1'b1;
    wait_clk(30);
    reset = 1'b1;
    wait_clk(3);
    chk("rst_data", {56'd0, rx_data}, 64'h00);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {62'd0, rx_done, framing_err}, 64'd0);
    reset = 1'b0;
    wait_clk(20);
    chk("post_rst_data", {56'd0, rx_data}, 64'h00);
    send_frame(8'h55, 1'b1);
    wait_clk(10);
    chk("55_data", {56'd0, rx_data}, 64'h55);

    // random frames, random gaps, occasional framing errors
    for (int i = 0; i < 12; i++) begin
      rd = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(rd, ok);
      if (!ok) begin
        wait_clk($urandom_range(0, 100));
        rx = 1'b1;
        wait_clk($urandom_range(4, 40));
      end else begin
        wait_clk($urandom_range(0, 40));
      end
    end

    // let outstanding pulses drain
    for (int i = 0; i < 1000 && q_kind.size() > 0; i++) @(negedge clk);
    if (q_kind.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d pulses never seen", q_kind.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
